arm_multicycle_controller: RTL and testbench

- Control unit for the multicycle variant of the ARM core, sequencing the shared ALU, instruction/data memory and register file over 3–5 cycles per instruction.
- Instruction classes: data-processing (ADD, SUB, AND, ORR, CMP; register or immediate), LDR/STR with immediate offset, and B.
- Holds the NZCV flag register and applies conditional execution to every architectural write.
- Sits beside the multicycle datapath inside top.

---
 rtl/arm_ctrl_pkg.sv | 60 ++++++
 rtl/arm_multicycle_controller_fsm.sv | 113 +++++++++++
 rtl/arm_multicycle_controller.sv | 163 ++++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath mux
// selects, ALU operations, data-processing opcodes and condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } statetype_e;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RM     = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    // Funct[4:1] opcode field of data-processing instructions
    localparam logic [3:0] DP_AND = 4'b0000;
    localparam logic [3:0] DP_SUB = 4'b0010;
    localparam logic [3:0] DP_ADD = 4'b0100;
    localparam logic [3:0] DP_CMP = 4'b1010;
    localparam logic [3:0] DP_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/arm_multicycle_controller_fsm.sv
// Main sequencer: state register, next-state logic and the raw per-state
// controls before condition gating. Current state is exported for debug.
module arm_main_fsm
    import arm_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] op_i,
    input  logic       funct5_i,
    input  logic       funct0_i,
    output logic [3:0] state_o,
    output logic       irwrite_o,
    output logic       nextpc_o,
    output logic       adrsrc_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] resultsrc_o,
    output logic       regw_o,
    output logic       memw_o,
    output logic       branch_o,
    output logic       aluop_o
);

    statetype_e state_q;
    statetype_e state_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        irwrite_o   = 1'b0;
        nextpc_o    = 1'b0;
        adrsrc_o    = 1'b0;
        alusrca_o   = 1'b0;
        alusrcb_o   = SRCB_RM;
        resultsrc_o = RES_ALUOUT;
        regw_o      = 1'b0;
        memw_o      = 1'b0;
        branch_o    = 1'b0;
        aluop_o     = 1'b0;
        case (state_q)
            FETCH: begin
                state_d     = DECODE;
                irwrite_o   = 1'b1;
                nextpc_o    = 1'b1;
                alusrca_o   = 1'b1;
                alusrcb_o   = SRCB_FOUR;
                resultsrc_o = RES_ALURESULT;
            end
            DECODE: begin
                // PC+4 is computed again here so branch targets see PC+8
                alusrca_o   = 1'b1;
                alusrcb_o   = SRCB_FOUR;
                resultsrc_o = RES_ALURESULT;
                case (op_i)
                    OP_MEM:    state_d = MEMADR;
                    OP_DP:     state_d = funct5_i ? EXECUTEI : EXECUTER;
                    OP_BRANCH: state_d = BRANCH;
                    default:   state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d   = funct0_i ? MEMRD : MEMWR;
                alusrcb_o = SRCB_EXTIMM;
            end
            MEMRD: begin
                state_d  = MEMWB;
                adrsrc_o = 1'b1;
            end
            MEMWB: begin
                state_d     = FETCH;
                resultsrc_o = RES_DATA;
                regw_o      = 1'b1;
            end
            MEMWR: begin
                state_d  = FETCH;
                adrsrc_o = 1'b1;
                memw_o   = 1'b1;
            end
            EXECUTER: begin
                state_d   = ALUWB;
                alusrcb_o = SRCB_RM;
                aluop_o   = 1'b1;
            end
            EXECUTEI: begin
                state_d   = ALUWB;
                alusrcb_o = SRCB_EXTIMM;
                aluop_o   = 1'b1;
            end
            ALUWB: begin
                state_d     = FETCH;
                resultsrc_o = RES_ALUOUT;
                regw_o      = 1'b1;
            end
            BRANCH: begin
                state_d     = FETCH;
                alusrcb_o   = SRCB_EXTIMM;
                resultsrc_o = RES_ALURESULT;
                branch_o    = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: main sequencer plus ALU decode, condition
// evaluation, NZCV flag register and write-enable gating.
module arm_multicycle_controller
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags
);

    logic [3:0] fsm_state;
    statetype_e state;
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       alu_op;

    arm_main_fsm u_fsm (
        .clk_i       (clk),
        .reset_i     (reset),
        .op_i        (Op),
        .funct5_i    (Funct[5]),
        .funct0_i    (Funct[0]),
        .state_o     (fsm_state),
        .irwrite_o   (irwrite),
        .nextpc_o    (nextpc),
        .adrsrc_o    (AdrSrc),
        .alusrca_o   (ALUSrcA),
        .alusrcb_o   (ALUSrcB),
        .resultsrc_o (ResultSrc),
        .regw_o      (regw),
        .memw_o      (memw),
        .branch_o    (branch),
        .aluop_o     (alu_op)
    );

    assign state = statetype_e'(fsm_state);

    logic [1:0] flag_w;
    logic       no_write_dec;

    always_comb begin
        ALUControl   = ALU_ADD;
        flag_w       = 2'b00;
        no_write_dec = 1'b0;
        if (alu_op) begin
            case (Funct[4:1])
                DP_ADD: begin
                    ALUControl = ALU_ADD;
                    flag_w     = Funct[0] ? 2'b11 : 2'b00;
                end
                DP_SUB: begin
                    ALUControl = ALU_SUB;
                    flag_w     = Funct[0] ? 2'b11 : 2'b00;
                end
                DP_AND: begin
                    ALUControl = ALU_AND;
                    flag_w     = Funct[0] ? 2'b10 : 2'b00;
                end
                DP_ORR: begin
                    ALUControl = ALU_ORR;
                    flag_w     = Funct[0] ? 2'b10 : 2'b00;
                end
                DP_CMP: begin
                    ALUControl   = ALU_SUB;
                    flag_w       = 2'b11;
                    no_write_dec = 1'b1;
                end
                default: begin
                    no_write_dec = 1'b1;
                end
            endcase
        end
    end

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex;
    logic       n_flag, z_flag, c_flag, v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            COND_EQ: cond_ex = z_flag;
            COND_NE: cond_ex = ~z_flag;
            COND_CS: cond_ex = c_flag;
            COND_CC: cond_ex = ~c_flag;
            COND_MI: cond_ex = n_flag;
            COND_PL: cond_ex = ~n_flag;
            COND_VS: cond_ex = v_flag;
            COND_VC: cond_ex = ~v_flag;
            COND_HI: cond_ex = c_flag & ~z_flag;
            COND_LS: cond_ex = ~c_flag | z_flag;
            COND_GE: cond_ex = (n_flag == v_flag);
            COND_LT: cond_ex = (n_flag != v_flag);
            COND_GT: cond_ex = ~z_flag & (n_flag == v_flag);
            COND_LE: cond_ex = z_flag | (n_flag != v_flag);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // flag_w is only non-zero in an EXECUTE state, so this commits on the
    // edge leaving EXECUTE, judged against the flags held before the update
    always_comb begin
        flags_d = flags_q;
        if (cond_ex) begin
            if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    logic no_write_q;
    logic no_write_d;

    assign no_write_d = alu_op ? no_write_dec : no_write_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= 4'b0000;
            no_write_q <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            no_write_q <= no_write_d;
        end
    end

    logic no_write;
    logic pcs;

    // ALUOp is low in ALUWB, so the decision captured in EXECUTE is used there
    assign no_write = (state == ALUWB) & no_write_q;
    assign pcs      = branch | (regw & (Rd == 4'b1111));

    assign PCWrite  = ~reset & (nextpc | (pcs & cond_ex));
    assign RegWrite = ~reset & regw & cond_ex & ~no_write;
    assign MemWrite = ~reset & memw & cond_ex;
    assign IRWrite  = ~reset & irwrite;
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == OP_MEM, Op == OP_BRANCH};
    assign Flags    = flags_q;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Directed per-cycle vector table for the multicycle ARM controller plus
// latency sequences for each instruction class.
module tb_arm_multicycle_controller;
    import arm_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] Flags;

    arm_multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .Flags      (Flags)
    );

    always #5 clk = ~clk;

    logic [3:0] dut_state;
    assign dut_state = dut.fsm_state;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
    } instr_t;

    typedef struct {
        logic       rst;
        instr_t     ins;
        logic [3:0] alufl;
        statetype_e st;
        logic       pcw;
        logic       memw;
        logic       regw;
        logic [1:0] aluc;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic instr_t mk(input logic [3:0] c, input logic [1:0] o,
                                  input logic [5:0] f, input logic [3:0] r);
        instr_t i;
        i.cond = c; i.op = o; i.funct = f; i.rd = r;
        return i;
    endfunction

    function automatic void add(input logic rst, input instr_t ins, input logic [3:0] alufl,
                                input statetype_e st, input logic pcw, input logic memw,
                                input logic regw, input logic [1:0] aluc, input logic [3:0] flags);
        vec_t v;
        v.rst = rst; v.ins = ins; v.alufl = alufl; v.st = st;
        v.pcw = pcw; v.memw = memw; v.regw = regw; v.aluc = aluc; v.flags = flags;
        vecs.push_back(v);
    endfunction

    // {IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB} expected in each state
    function automatic logic [6:0] mux_exp(input statetype_e st, input logic rst);
        case (st)
            FETCH:    return {~rst, 1'b0, 2'b10, 1'b1, 2'b10};
            DECODE:   return {1'b0, 1'b0, 2'b10, 1'b1, 2'b10};
            MEMADR:   return {1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
            MEMRD:    return {1'b0, 1'b1, 2'b00, 1'b0, 2'b00};
            MEMWB:    return {1'b0, 1'b0, 2'b01, 1'b0, 2'b00};
            MEMWR:    return {1'b0, 1'b1, 2'b00, 1'b0, 2'b00};
            EXECUTEI: return {1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
            BRANCH:   return {1'b0, 1'b0, 2'b10, 1'b0, 2'b01};
            default:  return 7'b0;
        endcase
    endfunction

    task automatic drive(input logic rst, input instr_t ins, input logic [3:0] alufl);
        reset    = rst;
        Cond     = ins.cond;
        Op       = ins.op;
        Funct    = ins.funct;
        Rd       = ins.rd;
        ALUFlags = alufl;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [23:0] act;
        logic [23:0] exp;
        exp = {4'(v.st), v.pcw, v.memw, v.regw, mux_exp(v.st, v.rst), v.aluc,
               v.ins.op, (v.ins.op == 2'b01), (v.ins.op == 2'b10), v.flags};
        act = {dut_state, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec%0d: got state/pcw/mw/rw/irw/adr/res/a/b/aluc/imm/rsrc/flags=%h expected %h",
                     idx, act, exp);
        end
    endtask

    task automatic latency(input string name, input instr_t ins, input int exp_cyc);
        int cyc;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(1'b0, ins, 4'b0000);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (dut_state != 4'(FETCH) && cyc < 12);
        n_vec++;
        if (cyc != exp_cyc) begin
            n_bad++;
            $display("FAIL latency_%s: got %0d cycles expected %0d", name, cyc, exp_cyc);
        end
    endtask

    instr_t add_i, subs_i, beq_i, bne_i, str_i, ldr_i, cmp_i, addpc_i, addpceq_i;
    instr_t orrs_i, subsne_i, and_i, nop_i, undef_i, strnv_i;

    initial begin
        add_i     = mk(4'hE, 2'b00, 6'b101000, 4'd2);
        subs_i    = mk(4'hE, 2'b00, 6'b100101, 4'd1);
        beq_i     = mk(4'h0, 2'b10, 6'b101000, 4'd0);
        bne_i     = mk(4'h1, 2'b10, 6'b101000, 4'd0);
        str_i     = mk(4'hE, 2'b01, 6'b011000, 4'd3);
        ldr_i     = mk(4'hE, 2'b01, 6'b011001, 4'd3);
        cmp_i     = mk(4'hE, 2'b00, 6'b010101, 4'd0);
        addpc_i   = mk(4'hE, 2'b00, 6'b001000, 4'd15);
        addpceq_i = mk(4'h0, 2'b00, 6'b001000, 4'd15);
        orrs_i    = mk(4'hE, 2'b00, 6'b011001, 4'd4);
        subsne_i  = mk(4'h1, 2'b00, 6'b000101, 4'd5);
        and_i     = mk(4'hE, 2'b00, 6'b000000, 4'd6);
        nop_i     = mk(4'hE, 2'b11, 6'b000000, 4'd0);
        undef_i   = mk(4'hE, 2'b00, 6'b001100, 4'd7);
        strnv_i   = mk(4'hF, 2'b01, 6'b011000, 4'd3);

        // rst, instr, ALUFlags, state, PCWrite, MemWrite, RegWrite, ALUControl, Flags
        add(0, add_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h0);
        add(0, add_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h0);
        add(0, add_i,     4'h0, EXECUTEI, 0, 0, 0, 2'b00, 4'h0);
        add(0, add_i,     4'hF, ALUWB,    0, 0, 1, 2'b00, 4'h0);
        add(0, subs_i,    4'h0, FETCH,    1, 0, 0, 2'b00, 4'h0);
        add(0, subs_i,    4'h0, DECODE,   0, 0, 0, 2'b00, 4'h0);
        add(0, subs_i,    4'h4, EXECUTEI, 0, 0, 0, 2'b01, 4'h0);
        add(0, subs_i,    4'hF, ALUWB,    0, 0, 1, 2'b00, 4'h4);
        add(0, beq_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, beq_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, beq_i,     4'h0, BRANCH,   1, 0, 0, 2'b00, 4'h4);
        add(0, bne_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, bne_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, bne_i,     4'h0, BRANCH,   0, 0, 0, 2'b00, 4'h4);
        add(0, str_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, str_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, str_i,     4'h0, MEMADR,   0, 0, 0, 2'b00, 4'h4);
        add(0, str_i,     4'h0, MEMWR,    0, 1, 0, 2'b00, 4'h4);
        add(0, ldr_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, ldr_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, ldr_i,     4'h0, MEMADR,   0, 0, 0, 2'b00, 4'h4);
        add(0, ldr_i,     4'h0, MEMRD,    0, 0, 0, 2'b00, 4'h4);
        add(0, ldr_i,     4'h0, MEMWB,    0, 0, 1, 2'b00, 4'h4);
        add(0, cmp_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, cmp_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, cmp_i,     4'h8, EXECUTER, 0, 0, 0, 2'b01, 4'h4);
        add(0, cmp_i,     4'h0, ALUWB,    0, 0, 0, 2'b00, 4'h8);
        add(0, addpc_i,   4'h0, FETCH,    1, 0, 0, 2'b00, 4'h8);
        add(0, addpc_i,   4'h0, DECODE,   0, 0, 0, 2'b00, 4'h8);
        add(0, addpc_i,   4'h0, EXECUTER, 0, 0, 0, 2'b00, 4'h8);
        add(0, addpc_i,   4'h0, ALUWB,    1, 0, 1, 2'b00, 4'h8);
        add(0, addpceq_i, 4'h0, FETCH,    1, 0, 0, 2'b00, 4'h8);
        add(0, addpceq_i, 4'h0, DECODE,   0, 0, 0, 2'b00, 4'h8);
        add(0, addpceq_i, 4'h0, EXECUTER, 0, 0, 0, 2'b00, 4'h8);
        add(0, addpceq_i, 4'h0, ALUWB,    0, 0, 0, 2'b00, 4'h8);
        add(0, orrs_i,    4'h0, FETCH,    1, 0, 0, 2'b00, 4'h8);
        add(0, orrs_i,    4'h0, DECODE,   0, 0, 0, 2'b00, 4'h8);
        add(0, orrs_i,    4'h7, EXECUTER, 0, 0, 0, 2'b11, 4'h8);
        add(0, orrs_i,    4'h0, ALUWB,    0, 0, 1, 2'b00, 4'h4);
        add(0, subsne_i,  4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, subsne_i,  4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, subsne_i,  4'h9, EXECUTER, 0, 0, 0, 2'b01, 4'h4);
        add(0, subsne_i,  4'h0, ALUWB,    0, 0, 0, 2'b00, 4'h4);
        add(0, and_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, and_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, and_i,     4'h0, EXECUTER, 0, 0, 0, 2'b10, 4'h4);
        add(0, and_i,     4'h0, ALUWB,    0, 0, 1, 2'b00, 4'h4);
        add(0, nop_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, nop_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, undef_i,   4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, undef_i,   4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, undef_i,   4'hF, EXECUTER, 0, 0, 0, 2'b00, 4'h4);
        add(0, undef_i,   4'h0, ALUWB,    0, 0, 0, 2'b00, 4'h4);
        add(0, strnv_i,   4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, strnv_i,   4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(0, strnv_i,   4'h0, MEMADR,   0, 0, 0, 2'b00, 4'h4);
        add(0, strnv_i,   4'h0, MEMWR,    0, 0, 0, 2'b00, 4'h4);
        // reset in MEMADR abandons the store and clears the flags
        add(0, str_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h4);
        add(0, str_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h4);
        add(1, str_i,     4'h0, MEMADR,   0, 0, 0, 2'b00, 4'h4);
        add(0, str_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h0);
        add(0, str_i,     4'h0, DECODE,   0, 0, 0, 2'b00, 4'h0);
        add(0, str_i,     4'h0, MEMADR,   0, 0, 0, 2'b00, 4'h0);
        // reset coinciding with MEMWR must still suppress the write strobe
        add(1, str_i,     4'h0, MEMWR,    0, 0, 0, 2'b00, 4'h0);
        add(0, nop_i,     4'h0, FETCH,    1, 0, 0, 2'b00, 4'h0);

        drive(1'b1, nop_i, 4'h0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ins, vecs[i].alufl);
            #2;
            check_vec(i, vecs[i]);
        end

        latency("ldr",   ldr_i,   5);
        latency("ldrnv", mk(4'hF, 2'b01, 6'b011001, 4'd3), 5);
        latency("str",   str_i,   4);
        latency("dp",    add_i,   4);
        latency("dpreg", and_i,   4);
        latency("b",     beq_i,   3);
        latency("nop",   nop_i,   2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
